// File: rtl/pipe_pkg.sv
// Shared pipeline constants: register width, stage bus widths and the
// boundary-register occupancy states.
package pipe_pkg;

  localparam int unsigned RegW          = 32;
  localparam int unsigned IF2IDBusSize  = 3 * RegW;  // pc, pc_prev, inst
  localparam int unsigned ID2EXBusSize  = 6 * RegW;
  localparam int unsigned EX2MEMBusSize = 4 * RegW;
  localparam int unsigned MEM2WBBusSize = 3 * RegW;
  localparam int unsigned PipeCntW      = 2;

  // Encoding doubles as the held-entry count.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic [RegW-1:0] pc;
    logic [RegW-1:0] pc_prev;
    logic [RegW-1:0] inst;
  } if2id_bus_t;

endpackage

// File: rtl/pipe_slot.sv
// One valid+data storage slot with load, drop and clear; data resets to RST_VAL.
module pipe_slot #(
  parameter int unsigned W        = 32,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter bit          CLR_DATA = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         drop_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  // Clear beats load beats drop; data is kept on drop so the bus stays stable.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_o <= 1'b0;
      data_o  <= RST_VAL;
    end else if (clr_i) begin
      valid_o <= 1'b0;
      if (CLR_DATA) data_o <= RST_VAL;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
    end else if (drop_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register: valid/ready handshake, synchronous flush,
// single register (DEPTH=1) or register plus skid slot (DEPTH=2).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned  W            = IF2IDBusSize,
  parameter int unsigned  DEPTH        = 1,
  parameter logic [W-1:0] RST_VAL      = '0,
  parameter bit           CLR_ON_FLUSH = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [W-1:0]        in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [W-1:0]        out_data_o,
  output logic [PipeCntW-1:0] count_o
);

  pipe_state_e  state_q, state_d;
  logic         main_valid, skid_valid;
  logic [W-1:0] skid_data, main_din;
  logic         in_xfer, out_xfer;
  logic         main_load, main_drop, main_from_skid;

  // DEPTH=2 ready depends only on registered state; DEPTH=1 looks through out_ready_i.
  assign in_ready_o  = (DEPTH == 2) ? (~flush_i & ~skid_valid)
                                    : (~flush_i & (~main_valid | out_ready_i));
  assign in_xfer     = in_valid_i & in_ready_o;
  assign out_xfer    = main_valid & out_ready_i;
  assign out_valid_o = main_valid;
  assign count_o     = PipeCntW'(state_q);
  assign main_din    = main_from_skid ? skid_data : in_data_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= PS_EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_drop      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      PS_EMPTY: begin
        if (in_xfer) begin
          main_load = 1'b1;
          state_d   = PS_ONE;
        end
      end
      PS_ONE: begin
        if (in_xfer && out_xfer) begin
          main_load = 1'b1;
        end else if (in_xfer) begin
          state_d = PS_FULL;
        end else if (out_xfer) begin
          main_drop = 1'b1;
          state_d   = PS_EMPTY;
        end
      end
      PS_FULL: begin
        if (out_xfer) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = PS_ONE;
        end
      end
      default: state_d = PS_EMPTY;
    endcase
    if (flush_i) state_d = PS_EMPTY;
  end

  pipe_slot #(
    .W       (W),
    .RST_VAL (RST_VAL),
    .CLR_DATA(CLR_ON_FLUSH)
  ) u_main (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr_i  (flush_i),
    .load_i (main_load),
    .drop_i (main_drop),
    .data_i (main_din),
    .valid_o(main_valid),
    .data_o (out_data_o)
  );

  if (DEPTH == 2) begin : g_skid
    logic skid_load;
    // Skid only fills when main is occupied and not draining.
    assign skid_load = (state_q == PS_ONE) & in_xfer & ~out_xfer;

    pipe_slot #(
      .W       (W),
      .RST_VAL (RST_VAL),
      .CLR_DATA(CLR_ON_FLUSH)
    ) u_skid (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .clr_i  (flush_i),
      .load_i (skid_load),
      .drop_i (main_from_skid),
      .data_i (in_data_i),
      .valid_o(skid_valid),
      .data_o (skid_data)
    );
  end else if (DEPTH == 1) begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_data  = RST_VAL;
  end else begin : g_bad_depth
    $error("pipe_stage_reg: DEPTH must be 1 or 2");
    assign skid_valid = 1'b0;
    assign skid_data  = RST_VAL;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: DEPTH=1 and DEPTH=2 instances driven by the same
// stimulus, each checked every cycle against a queue model plus literal points.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned W = IF2IDBusSize;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         rdy1, ov1, rdy2, ov2;
  logic [W-1:0] od1, od2;
  logic [1:0]   cnt1, cnt2;

  pipe_stage_reg #(.W(W), .DEPTH(1)) d1 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(rdy1), .in_data_i(in_data),
    .out_valid_o(ov1), .out_ready_i(out_ready), .out_data_o(od1), .count_o(cnt1)
  );

  pipe_stage_reg #(.W(W), .DEPTH(2)) d2 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(rdy2), .in_data_i(in_data),
    .out_valid_o(ov2), .out_ready_i(out_ready), .out_data_o(od2), .count_o(cnt2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: queue of held payloads; hold = register contents when the queue is empty.
  logic [W-1:0] q1[$], q2[$];
  logic [W-1:0] hold1 = '0, hold2 = '0;
  bit r1, r2, in1, in2, o1, o2;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      r1 = !flush && (q1.size() == 0 || out_ready);
      r2 = !flush && (q2.size() < 2);
      chk("d1_ready", W'(rdy1), W'(r1));
      chk("d1_valid", W'(ov1), W'(q1.size() != 0));
      chk("d1_data",  od1, (q1.size() != 0) ? q1[0] : hold1);
      chk("d1_count", W'(cnt1), W'(q1.size()));
      chk("d1_count_le_depth", W'(cnt1 <= 2'd1), W'(1));
      chk("d2_ready", W'(rdy2), W'(r2));
      chk("d2_valid", W'(ov2), W'(q2.size() != 0));
      chk("d2_data",  od2, (q2.size() != 0) ? q2[0] : hold2);
      chk("d2_count", W'(cnt2), W'(q2.size()));
      chk("d2_skid_implies_valid", W'((cnt2 != 2'd2) || ov2), W'(1));
      in1 = in_valid && r1;
      o1  = (q1.size() != 0) && out_ready;
      in2 = in_valid && r2;
      o2  = (q2.size() != 0) && out_ready;
    end
  end

  always @(posedge clk) begin
    if (!rst_n || flush) begin
      q1.delete();
      q2.delete();
      hold1 <= '0;
      hold2 <= '0;
    end else if (chk_en) begin
      if (o1)  hold1 <= q1.pop_front();
      if (in1) q1.push_back(in_data);
      if (o2)  hold2 <= q2.pop_front();
      if (in2) q2.push_back(in_data);
    end
  end

  task automatic step(bit rn, bit fl, bit iv, logic [W-1:0] d, bit ordy);
    @(posedge clk);
    #1;
    rst_n     = rn;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = W'('h77); out_ready = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    step(1'b0, 1'b0, 1'b1, W'('h77), 1'b0);

    // Reset release
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("rst_d2_valid", W'(ov2),  '0);
    chk("rst_d2_count", W'(cnt2), '0);
    chk("rst_d2_data",  od2,      '0);
    chk("rst_d2_ready", W'(rdy2), W'(1));

    // Back-to-back stream, no bubbles
    step(1'b1, 1'b0, 1'b1, W'('h10), 1'b1);
    step(1'b1, 1'b0, 1'b1, W'('h14), 1'b1);
    chk("stream1_d1", od1, W'('h10));
    chk("stream1_d2", od2, W'('h10));
    step(1'b1, 1'b0, 1'b1, W'('h18), 1'b1);
    chk("stream2_d1", od1, W'('h14));
    chk("stream2_d2", od2, W'('h14));
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("stream3_d1", od1, W'('h18));
    chk("stream3_d2", od2, W'('h18));
    chk("stream3_v2", W'(ov2), W'(1));
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("stream_end_v1", W'(ov1), '0);
    chk("stream_end_v2", W'(ov2), '0);

    // Stall under back-pressure
    step(1'b1, 1'b0, 1'b1, W'('hA), 1'b0);
    step(1'b1, 1'b0, 1'b1, W'('hB), 1'b0);
    chk("stall_d2_cnt1", W'(cnt2), W'(1));
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("stall_d2_cnt2",  W'(cnt2), W'(2));
    chk("stall_d2_ready", W'(rdy2), '0);
    chk("stall_d2_head",  od2, W'('hA));
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, W'('h55), 1'b0);
      chk("stall_d1_ready", W'(rdy1), '0);
      chk("stall_d1_hold",  od1, W'('hA));
      chk("stall_d1_valid", W'(ov1), W'(1));
    end
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("drain_d2_first", od2, W'('hA));
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("drain_d2_second", od2, W'('hB));
    chk("drain_d2_ready",  W'(rdy2), W'(1));
    chk("drain_d2_cnt",    W'(cnt2), W'(1));
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("drain_d2_empty", W'(ov2), '0);

    // Flush of a full block with a pending input
    step(1'b1, 1'b0, 1'b1, W'('hA), 1'b0);
    step(1'b1, 1'b0, 1'b1, W'('hB), 1'b0);
    step(1'b1, 1'b1, 1'b1, W'('hC), 1'b0);
    chk("flush_d2_ready", W'(rdy2), '0);
    chk("flush_d1_ready", W'(rdy1), '0);
    chk("flush_d2_full",  W'(cnt2), W'(2));
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("flush_d2_valid", W'(ov2),  '0);
    chk("flush_d2_cnt",   W'(cnt2), '0);
    chk("flush_d2_data",  od2,      '0);
    chk("flush_d1_data",  od1,      '0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      chk("flush_no_c", W'(ov2), '0);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, W'('hD), 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 9) < 7),
           {$urandom(), $urandom(), $urandom()},
           ($urandom_range(0, 9) < 6));
    end
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline boundary register that replaces the per-stage hand-written registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a W-bit payload bus with a valid/ready handshake, synchronous flush and optional 2-entry skid buffering.
- Stall comes from back-pressure: out_ready_i low.
- Instantiated once per stage boundary; the payload is the stage bus, e.g. the IF2ID bus of {pc, pc_prev, inst}.

Parameters:
- W, 96, payload width in bits.
- DEPTH, 1, storage entries. 1 = single register with combinational ready. 2 = register plus skid slot with registered ready. Other values are illegal; reject them at elaboration.
- RST_VAL, {W{1'b0}}, payload value after reset, and after flush when CLR_ON_FLUSH=1.
- CLR_ON_FLUSH, 1, 1 = flush also loads RST_VAL into the data registers; 0 = data registers hold their value.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n_i  in  1  synchronous reset, active-low.
- flush_i  in  1  synchronous flush: discard all held entries.
- in_valid_i  in  1  upstream has a payload.
- in_ready_o  out  1  block can accept a payload this cycle.
- in_data_i  in  W  upstream payload.
- out_valid_o  out  1  out_data_o is valid.
- out_ready_i  in  1  downstream accepts this cycle.
- out_data_o  out  W  payload to the next stage.
- count_o  out  2  entries held (0..DEPTH).

Behaviour:
- Transfers:
  - Input transfer = in_valid_i & in_ready_o.
  - Output transfer = out_valid_o & out_ready_i.
  - in_valid_i must not depend on in_ready_o; out_ready_i may depend on out_valid_o.
- Reset (rst_n_i=0 at an edge): out_valid_o=0, skid empty, count_o=0, out_data_o=RST_VAL, skid data=RST_VAL. Reset overrides flush and all transfers, including reset asserted mid-stall with a full skid.
- Latency: empty block, input transfer in cycle N → out_valid_o=1 with that payload in cycle N+1. No combinational path from in_data_i to out_data_o.
- Ordering: strict FIFO order. No payload is lost or duplicated except by flush or reset.
- out_data_o and out_valid_o are driven directly from the main register (registered outputs).
- DEPTH=1:
  - in_ready_o = ~flush_i & (~out_valid_o | out_ready_i). This is combinational through out_ready_i.
  - On input transfer: main ← in_data_i, valid ← 1.
  - On output transfer without input transfer: valid ← 0.
  - Simultaneous input and output transfer: main ← new payload, valid stays 1. This gives full throughput.
- DEPTH=2:
  - in_ready_o = ~flush_i & ~skid_valid. This depends only on registered state and flush_i.
  - States:
    - EMPTY (count 0)
    - ONE (main valid, skid empty)
    - FULL (both valid)
  - EMPTY: input transfer → ONE, main ← in.
  - ONE:
    - input & output transfer → ONE, main ← in.
    - input only → FULL, skid ← in, main held.
    - output only → EMPTY.
  - FULL (in_ready_o=0):
    - output transfer → ONE, main ← skid.
    - otherwise hold.
  - Sustained full throughput is required with out_ready_i=1.
- Flush (flush_i=1, rst_n_i=1):
  - in_ready_o forced 0 in the same cycle, so no input transfer occurs.
  - At the edge: out_valid_o ← 0, skid_valid ← 0, count_o ← 0.
  - Data registers ← RST_VAL if CLR_ON_FLUSH, else held.
  - An output transfer in the flush cycle is still a legal handshake; downstream owns that payload.
  - Flush held for several cycles keeps the block EMPTY.
- count_o is registered: {skid_valid & main_valid, main_valid ^ skid_valid}, i.e. the encoding 0/1/2. It is always ≤ DEPTH.
- Invariant: skid_valid → out_valid_o.

Decomposition:
- Shared package pipe_pkg: RegW=32 and the stage bus widths (IF2IDBusSize=3*RegW, ID2EXBusSize, …). Instances take W from these constants.
- One sub-module, pipe_slot: a single valid+data register with load, clear and RST_VAL. It is instantiated once for main and once for skid, the skid slot under generate for DEPTH=2.
- Handshake and state logic stay in pipe_stage_reg.

Test Plan:
- Reset, DEPTH=2, W=96: hold rst_n_i=0 for 2 cycles with in_valid_i=1 → out_valid_o=0, count_o=0, out_data_o=0, in_ready_o=1 on release.
- Streaming, DEPTH=1 and 2, out_ready_i=1: send 0x10,0x14,0x18 back-to-back → out_data_o shows 0x10,0x14,0x18 on consecutive cycles, starting 1 cycle after the first transfer, with no bubbles.
- Stall, DEPTH=2: send 0xA then 0xB while out_ready_i=0 → count_o=2 and in_ready_o=0 next cycle. Raise out_ready_i → 0xA then 0xB delivered in order; in_ready_o=1 the cycle after 0xA leaves.
- Stall, DEPTH=1: out_valid_o=1 and out_ready_i=0 → in_ready_o=0 same cycle; payload held stable for 5 cycles.
- Flush, DEPTH=2, full with 0xA/0xB and in_valid_i=1 with 0xC: pulse flush_i for 1 cycle → in_ready_o=0 that cycle; next cycle out_valid_o=0, count_o=0, out_data_o=RST_VAL; 0xC is never output.
- Random: random valid, ready and flush for 10k cycles against a scoreboard queue → output order matches and no loss/duplication between flushes. Check invariants: count_o ≤ DEPTH, and skid_valid → out_valid_o.
